// File: rtl/ram_initiator_pkg.sv
// Shared op-codes and FSM state type for the ram_initiator command front end.
package ram_initiator_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    FILL,
    RESP
  } state_t;

endpackage

// File: rtl/ram.sv
// Single-port RAM: posedge-registered read, negedge write.
module ram #(
  parameter int ADDRESS_MAX  = 16,
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    read_memory,
  input  logic                    write_memory,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   write_memory_data,
  output logic [DATA_WIDTH-1:0]   read_memory_data
);

  logic [DATA_WIDTH-1:0] mem [ADDRESS_MAX];

  always_ff @(negedge clk) begin
    if (write_memory && (32'(address) < ADDRESS_MAX))
      mem[address] <= write_memory_data;
  end

  always_ff @(posedge clk) begin
    if (read_memory && (32'(address) < ADDRESS_MAX))
      read_memory_data <= mem[address];
  end

endmodule

// File: rtl/ram_initiator.sv
// Command-driven initiator for the single-port ram: read, write and fill
// commands in, one response per command out, RAM strobes with RAM timing.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int ADDRESS_MAX  = 16,
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDRESS_BITS-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_error,
  output logic                    read_memory,
  output logic                    write_memory,
  output logic [ADDRESS_BITS-1:0] address,
  output logic [DATA_WIDTH-1:0]   write_memory_data,
  input  logic [DATA_WIDTH-1:0]   read_memory_data
);

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(ADDRESS_MAX - 1);

  state_t state, state_next;
  logic   cmd_error;

  // Fill ignores cmd_address, so only read/write are range-checked.
  assign cmd_error = (cmd_op == OP_RSVD) ||
                     ((cmd_op != OP_FILL) && (32'(cmd_address) >= ADDRESS_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    read_memory  = 1'b0;
    write_memory = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_error) state_next = RESP;
          else begin
            case (cmd_op)
              OP_READ:  state_next = RD;
              OP_WRITE: state_next = WR;
              OP_FILL:  state_next = FILL;
              default:  state_next = RESP;
            endcase
          end
        end
      end
      WR: begin
        write_memory = 1'b1;
        state_next   = RESP;
      end
      RD: begin
        read_memory = 1'b1;
        state_next  = RD_WAIT;
      end
      RD_WAIT: state_next = RESP;
      FILL: begin
        write_memory = 1'b1;
        if (address == LAST_ADDR) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      address           <= '0;
      write_memory_data <= '0;
      rsp_data          <= '0;
      rsp_error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_data  <= '0;
            rsp_error <= cmd_error;
            if (!cmd_error) begin
              address <= (cmd_op == OP_FILL) ? '0 : cmd_address;
              if (cmd_op != OP_READ) write_memory_data <= cmd_data;
            end
          end
        end
        RD_WAIT: rsp_data <= read_memory_data;
        // Saturate at the last word so a short RAM never sees a wrapped address.
        FILL: if (address != LAST_ADDR) address <= address + ADDRESS_BITS'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator driving ram; two instances (16 and 12 words).
module tb_ram_initiator;
  import ram_initiator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_address;
  logic [15:0] cmd_data;
  logic        rsp_ready;

  logic        rdy16, rv16, err16, rm16, wm16, rdy12, rv12, err12, rm12, wm12;
  logic [15:0] rd16, wd16, rmd16, rd12, wd12, rmd12;
  logic [3:0]  a16, a12;

  logic        c_cmd_ready, c_rsp_valid, c_rsp_error, c_wr, c_rd;
  logic [15:0] c_rsp_data, c_wdata;
  logic [3:0]  c_addr;

  always #5 clk = ~clk;

  ram_initiator #(.ADDRESS_MAX(16), .ADDRESS_BITS(4), .DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(rdy16),
    .cmd_op(cmd_op), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rv16), .rsp_ready(rsp_ready), .rsp_data(rd16), .rsp_error(err16),
    .read_memory(rm16), .write_memory(wm16), .address(a16),
    .write_memory_data(wd16), .read_memory_data(rmd16));
  ram #(.ADDRESS_MAX(16), .ADDRESS_BITS(4), .DATA_WIDTH(16)) ram16 (
    .clk(clk), .read_memory(rm16), .write_memory(wm16), .address(a16),
    .write_memory_data(wd16), .read_memory_data(rmd16));

  ram_initiator #(.ADDRESS_MAX(12), .ADDRESS_BITS(4), .DATA_WIDTH(16)) dut12 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & sel), .cmd_ready(rdy12),
    .cmd_op(cmd_op), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rv12), .rsp_ready(rsp_ready), .rsp_data(rd12), .rsp_error(err12),
    .read_memory(rm12), .write_memory(wm12), .address(a12),
    .write_memory_data(wd12), .read_memory_data(rmd12));
  ram #(.ADDRESS_MAX(12), .ADDRESS_BITS(4), .DATA_WIDTH(16)) ram12 (
    .clk(clk), .read_memory(rm12), .write_memory(wm12), .address(a12),
    .write_memory_data(wd12), .read_memory_data(rmd12));

  assign c_cmd_ready = sel ? rdy12 : rdy16;
  assign c_rsp_valid = sel ? rv12  : rv16;
  assign c_rsp_error = sel ? err12 : err16;
  assign c_rsp_data  = sel ? rd12  : rd16;
  assign c_wr        = sel ? wm12  : wm16;
  assign c_rd        = sel ? rm12  : rm16;
  assign c_addr      = sel ? a12   : a16;
  assign c_wdata     = sel ? wd12  : wd16;

  int checks = 0;
  int failures = 0;

  // Reference memories: word contents and which words hold known data.
  logic [15:0] model16 [16];
  logic [15:0] model12 [12];
  bit          valid16 [16];

  int          lat;
  logic [15:0] got_data;
  logic        got_err;
  int          rd_cnt;
  logic [3:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  logic [19:0] snap_q    [$];

  // Issue one command, record strobes (cycle k = T+k), latency and response.
  task automatic do_cmd(input bit s, input logic [1:0] op, input logic [3:0] a,
                        input logic [15:0] d, input int stall, input bit intrude);
    int w;
    sel = s;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); snap_q.delete();
    rd_cnt = 0; lat = -1; got_data = 'x; got_err = 1'bx;
    @(negedge clk);
    cmd_op = op; cmd_address = a; cmd_data = d; cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    w = 0;
    while (!c_cmd_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (c_wr) begin wr_addr_q.push_back(c_addr); wr_data_q.push_back(c_wdata); wr_cyc_q.push_back(k); end
      if (c_rd) rd_cnt++;
      if (c_rsp_valid) begin lat = k; got_data = c_rsp_data; got_err = c_rsp_error; break; end
    end
    if (lat > 0 && stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        snap_q.push_back({c_rsp_valid, c_cmd_ready, c_wr, c_rd, c_rsp_data});
        if (intrude) begin
          cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_address = a ^ 4'd1; cmd_data = ~d;
        end
        @(negedge clk);
      end
      snap_q.push_back({c_rsp_valid, c_cmd_ready, c_wr, c_rd, c_rsp_data});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = OP_READ; cmd_address = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy16, rv16, err16, rm16, wm16, a16, wd16, rd16} !== {1'b1, 4'b0, 4'b0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset16 got rdy=%b rv=%b err=%b rm=%b wm=%b a=%h wd=%h rd=%h want rdy=1 rest 0",
               rdy16, rv16, err16, rm16, wm16, a16, wd16, rd16);
    end
    checks++;
    if ({rdy12, rv12, err12, rm12, wm12, a12, wd12, rd12} !== {1'b1, 4'b0, 4'b0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset12 got rdy=%b rv=%b err=%b rm=%b wm=%b a=%h wd=%h rd=%h want rdy=1 rest 0",
               rdy12, rv12, err12, rm12, wm12, a12, wd12, rd12);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [3:0]  a, b;
    logic [15:0] d;
    logic [19:0] first;
    do_cmd(1'b0, OP_WRITE, 4'd3, 16'hA5A5, 0, 1'b0);
    model16[3] = 16'hA5A5; valid16[3] = 1'b1;
    first = (wr_addr_q.size() > 0) ? {wr_addr_q[0], wr_data_q[0]} : 'x;
    checks++;
    if (lat !== 2 || got_err !== 1'b0 || got_data !== 16'h0) begin
      failures++;
      $display("FAIL write_rsp got lat=%0d err=%b data=%h want lat=2 err=0 data=0000", lat, got_err, got_data);
    end
    checks++;
    if (wr_addr_q.size() != 1 || rd_cnt != 0 || first !== {4'd3, 16'hA5A5} || wr_cyc_q[0] != 1) begin
      failures++;
      $display("FAIL write_strobe got n_wr=%0d n_rd=%0d first=%h want n_wr=1 n_rd=0 first=3a5a5 at T+1",
               wr_addr_q.size(), rd_cnt, first);
    end
    do_cmd(1'b0, OP_READ, 4'd3, 16'($urandom), 0, 1'b0);
    checks++;
    if (lat !== 3 || got_err !== 1'b0 || got_data !== 16'hA5A5 || rd_cnt != 1 || wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL read_rsp got lat=%0d err=%b data=%h n_rd=%0d n_wr=%0d want lat=3 err=0 data=a5a5 n_rd=1 n_wr=0",
               lat, got_err, got_data, rd_cnt, wr_addr_q.size());
    end
    for (int n = 0; n < 8; n++) begin
      a = 4'($urandom_range(15)); d = 16'($urandom);
      do_cmd(1'b0, OP_WRITE, a, d, 0, 1'b0);
      model16[a] = d; valid16[a] = 1'b1;
      do b = 4'($urandom_range(15)); while (!valid16[b]);
      do_cmd(1'b0, OP_READ, b, 16'($urandom), 0, 1'b0);
      checks++;
      if (lat !== 3 || got_err !== 1'b0 || got_data !== model16[b]) begin
        failures++;
        $display("FAIL rand_read[%0d] addr=%0d got lat=%0d err=%b data=%h want lat=3 err=0 data=%h",
                 n, b, lat, got_err, got_data, model16[b]);
      end
    end
  endtask

  task automatic test_fill();
    logic [15:0] pat;
    logic [3:0]  b;
    int bad;
    for (int n = 0; n < 2; n++) begin
      pat = (n == 0) ? 16'h1234 : 16'($urandom);
      do_cmd(1'b0, OP_FILL, 4'($urandom), pat, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin model16[i] = pat; valid16[i] = 1'b1; end
      bad = 0;
      for (int j = 0; j < wr_addr_q.size(); j++)
        if (wr_addr_q[j] !== 4'(j) || wr_data_q[j] !== pat || wr_cyc_q[j] != j + 1) bad++;
      checks++;
      if (lat !== 17 || got_err !== 1'b0 || got_data !== 16'h0 || wr_addr_q.size() != 16 || bad != 0 || rd_cnt != 0) begin
        failures++;
        $display("FAIL fill[%0d] got lat=%0d err=%b data=%h n_wr=%0d bad_seq=%0d n_rd=%0d want lat=17 err=0 data=0 n_wr=16 bad_seq=0 n_rd=0",
                 n, lat, got_err, got_data, wr_addr_q.size(), bad, rd_cnt);
      end
      for (int r = 0; r < 3; r++) begin
        b = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(15));
        do_cmd(1'b0, OP_READ, b, 16'h0, 0, 1'b0);
        checks++;
        if (got_data !== pat || got_err !== 1'b0) begin
          failures++;
          $display("FAIL fill_read[%0d] addr=%0d got data=%h err=%b want data=%h err=0", n, b, got_data, got_err, pat);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [15:0] pat;
    logic [1:0]  ops [4];
    logic [3:0]  adrs [4];
    bit          s12 [4];
    int bad;
    pat = 16'($urandom);
    do_cmd(1'b1, OP_FILL, 4'd9, pat, 0, 1'b0);
    for (int i = 0; i < 12; i++) model12[i] = pat;
    bad = 0;
    for (int j = 0; j < wr_addr_q.size(); j++)
      if (wr_addr_q[j] !== 4'(j) || wr_data_q[j] !== pat) bad++;
    checks++;
    if (lat !== 13 || wr_addr_q.size() != 12 || bad != 0) begin
      failures++;
      $display("FAIL fill12 got lat=%0d n_wr=%0d bad_seq=%0d want lat=13 n_wr=12 bad_seq=0", lat, wr_addr_q.size(), bad);
    end
    do_cmd(1'b1, OP_READ, 4'd11, 16'h0, 0, 1'b0);
    checks++;
    if (lat !== 3 || got_err !== 1'b0 || got_data !== model12[11]) begin
      failures++;
      $display("FAIL read12_last got lat=%0d err=%b data=%h want lat=3 err=0 data=%h", lat, got_err, got_data, model12[11]);
    end
    ops  = '{OP_READ, OP_RSVD, OP_WRITE, OP_RSVD};
    adrs = '{4'd13,   4'd2,    4'd12,    4'd5};
    s12  = '{1'b1,    1'b1,    1'b1,     1'b0};
    for (int n = 0; n < 4; n++) begin
      do_cmd(s12[n], ops[n], adrs[n], 16'($urandom), 0, 1'b0);
      checks++;
      if (lat !== 1 || got_err !== 1'b1 || got_data !== 16'h0 || wr_addr_q.size() != 0 || rd_cnt != 0) begin
        failures++;
        $display("FAIL error[%0d] op=%b addr=%0d got lat=%0d err=%b data=%h n_wr=%0d n_rd=%0d want lat=1 err=1 data=0 no strobes",
                 n, ops[n], adrs[n], lat, got_err, got_data, wr_addr_q.size(), rd_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a;
    int bad;
    a = 4'($urandom_range(15));
    do_cmd(1'b0, OP_WRITE, a, 16'hBEEF, 0, 1'b0);
    model16[a] = 16'hBEEF;
    do_cmd(1'b0, OP_READ, a, 16'h0, 5, 1'b1);
    bad = 0;
    foreach (snap_q[i]) if (snap_q[i] !== {1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF}) bad++;
    checks++;
    if (lat !== 3 || got_data !== 16'hBEEF || snap_q.size() != 6 || bad != 0) begin
      failures++;
      $display("FAIL backpressure got lat=%0d data=%h snaps=%0d bad=%0d want lat=3 data=beef snaps=6 bad=0",
               lat, got_data, snap_q.size(), bad);
    end
    do_cmd(1'b0, OP_READ, a ^ 4'd1, 16'h0, 0, 1'b0);
    checks++;
    if (got_data !== model16[a ^ 4'd1]) begin
      failures++;
      $display("FAIL bp_ignored_cmd addr=%0d got data=%h want %h", a ^ 4'd1, got_data, model16[a ^ 4'd1]);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] pat;
    logic [3:0]  b;
    int bad;
    sel = 1'b0;
    pat = 16'($urandom) | 16'h0001;
    @(negedge clk);
    cmd_op = OP_FILL; cmd_data = pat; cmd_address = 4'($urandom); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (c_wr !== 1'b1 || c_addr !== 4'd4) begin
      failures++;
      $display("FAIL fill_cycle5 got wr=%b addr=%0d want wr=1 addr=4", c_wr, c_addr);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_wr, c_rd, c_rsp_valid, c_cmd_ready, c_addr, c_wdata, c_rsp_data} !== {4'b0001, 4'h0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL mid_reset got wr=%b rd=%b rv=%b rdy=%b a=%h wd=%h rd=%h want rdy=1 rest 0",
               c_wr, c_rd, c_rsp_valid, c_cmd_ready, c_addr, c_wdata, c_rsp_data);
    end
    bad = 0;
    repeat (20) begin @(negedge clk); if (c_wr || c_rd || c_rsp_valid) bad++; end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet got active_cycles=%0d want 0", bad);
    end
    for (int i = 0; i < 5; i++) model16[i] = pat;
    for (int r = 0; r < 3; r++) begin
      b = (r == 0) ? 4'd0 : (r == 1) ? 4'd4 : 4'($urandom_range(15, 5));
      do_cmd(1'b0, OP_READ, b, 16'h0, 0, 1'b0);
      checks++;
      if (lat !== 3 || got_data !== model16[b]) begin
        failures++;
        $display("FAIL post_reset_read addr=%0d got lat=%0d data=%h want lat=3 data=%h", b, lat, got_data, model16[b]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) valid16[i] = 1'b0;
    test_reset();
    test_write_read();
    test_fill();
    test_errors();
    test_backpressure();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
